// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals grouped into one bundle.
// The slave modport is the arbiter's view; master is the view of the requesting
// masters and the shared-bus monitor that drives the observed bus lines.
interface bus_arbiter_if;
    logic [3:0] request;
    logic [3:0] granted;
    logic       beginTransactionIn;
    logic       endTransactionIn;
    logic       dataValidIn;
    logic       errorIn;
    logic       endTransactionOut;
    logic       errorOut;
    logic [1:0] activeMaster;
    logic       busOwned;

    modport slave (
        input  request, beginTransactionIn, endTransactionIn, dataValidIn, errorIn,
        output granted, endTransactionOut, errorOut, activeMaster, busOwned
    );

    modport master (
        output request, beginTransactionIn, endTransactionIn, dataValidIn, errorIn,
        input  granted, endTransactionOut, errorOut, activeMaster, busOwned
    );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with a begin-transaction timeout and an
// idle-bus watchdog that aborts a stalled transaction.
// Every output is a flop loaded from the next-state logic, so no input reaches
// an output combinationally.
module bus_arbiter #(
    parameter int GRANT_TIMEOUT = 16,
    parameter int BUS_TIMEOUT   = 255
) (
    input  logic           clock,
    input  logic           reset,
    bus_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, GRANT, WAIT_BEGIN, OWNED, ABORT} state_t;

    // Last counted cycle before each timeout fires.
    localparam logic [7:0] GRANT_LAST = 8'(GRANT_TIMEOUT - 1);
    localparam logic [7:0] BUS_LAST   = 8'(BUS_TIMEOUT - 1);

    state_t     state, next_state;
    logic [1:0] last_grant, next_last_grant;
    logic [1:0] owner, next_owner;
    logic [7:0] wait_count, next_wait_count;
    logic [7:0] watchdog, next_watchdog;
    logic [1:0] winner, candidate;
    logic       found;

    // Round-robin pick: first requester searching upward from last_grant + 1.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        winner    = last_grant;
        candidate = '0;
        found     = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            candidate = last_grant + 2'(i);
            if (!found && bus.request[candidate]) begin
                winner = candidate;
                found  = 1'b1;
            end
        end
    end

    // Next-state, owner latch and timeout counters.
    always_comb begin
        next_state      = state;
        next_owner      = owner;
        next_last_grant = last_grant;
        next_wait_count = wait_count;
        next_watchdog   = watchdog;
        case (state)
            IDLE: begin
                if (|bus.request) begin
                    next_state      = GRANT;
                    next_owner      = winner;
                    next_last_grant = winner;
                end
            end
            GRANT: begin
                next_state      = WAIT_BEGIN;
                next_wait_count = '0;
            end
            WAIT_BEGIN: begin
                // A begin on the last allowed cycle still wins over the timeout.
                if (bus.beginTransactionIn) begin
                    next_state    = bus.endTransactionIn ? IDLE : OWNED;
                    next_watchdog = '0;
                end else if (wait_count == GRANT_LAST) begin
                    next_state = IDLE;
                end else begin
                    next_wait_count = wait_count + 8'd1;
                end
            end
            OWNED: begin
                if (bus.endTransactionIn || bus.errorIn) begin
                    next_state = IDLE;
                end else if (bus.dataValidIn) begin
                    next_watchdog = '0;
                end else if (watchdog == BUS_LAST) begin
                    next_state = ABORT;
                end else begin
                    next_watchdog = watchdog + 8'd1;
                end
            end
            // End-of-transaction seen during the abort cycle changes nothing.
            ABORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State and counter registers; reset leaves master 0 first in line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= 2'd3;
            wait_count <= '0;
            watchdog   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= next_state;
            owner      <= next_owner;
            last_grant <= next_last_grant;
            wait_count <= next_wait_count;
            watchdog   <= next_watchdog;
        end
    end

    // Output flops, loaded from the state being entered so they align with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.granted           <= '0;
            bus.busOwned          <= 1'b0;
            bus.endTransactionOut <= 1'b0;
            bus.errorOut          <= 1'b0;
        end else begin
            bus.granted           <= (next_state == GRANT) ? (4'b0001 << next_owner) : 4'b0000;
            bus.busOwned          <= (next_state != IDLE);
            bus.endTransactionOut <= (next_state == ABORT);
            bus.errorOut          <= (next_state == ABORT);
        end
    end

    assign bus.activeMaster = owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transactions against a transaction-level round-robin and timing model.
module tb_bus_arbiter;

    localparam int GRANT_TIMEOUT = 16;
    localparam int BUS_TIMEOUT   = 255;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   last_grant;

    bus_arbiter_if arb_bus ();

    bus_arbiter #(.GRANT_TIMEOUT(GRANT_TIMEOUT), .BUS_TIMEOUT(BUS_TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (arb_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view {granted, busOwned, endTransactionOut, errorOut}.
    function automatic logic [6:0] status();
        return {arb_bus.granted, arb_bus.busOwned, arb_bus.endTransactionOut, arb_bus.errorOut};
    endfunction

    // Reference arbitration rule: first set bit from (last + 1) mod 4 upward.
    function automatic int rr_winner(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (req[c]) return c;
        end
        return last;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        arb_bus.request            = '0;
        arb_bus.beginTransactionIn = 1'b0;
        arb_bus.endTransactionIn   = 1'b0;
        arb_bus.dataValidIn        = 1'b0;
        arb_bus.errorIn            = 1'b0;
    endtask

    // Request while idle, check the one-cycle grant pulse and owner index,
    // then scramble the request lines to show they no longer matter.
    task automatic grant_phase(input logic [3:0] req, input string tag, output int w);
        w = rr_winner(req, last_grant);
        last_grant = w;
        arb_bus.request = req;
        tick();
        n_cmp++;
        if (status() !== {4'(1 << w), 3'b100}) begin
            n_err++;
            $display("FAIL %s grant: got %b want %b", tag, status(), {4'(1 << w), 3'b100});
        end
        n_cmp++;
        if (arb_bus.activeMaster !== 2'(w)) begin
            n_err++;
            $display("FAIL %s owner: got %0d want %0d", tag, arb_bus.activeMaster, w);
        end
        arb_bus.request = 4'($urandom);
        tick();
        n_cmp++;
        if (status() !== 7'b0000100) begin
            n_err++;
            $display("FAIL %s pulse_end: got %b want 0000100", tag, status());
        end
    endtask

    // One transaction: begin after begin_delay wait cycles (>= GRANT_TIMEOUT means
    // never), stay owned owned_len cycles (0 = begin and end together), then end.
    task automatic run_txn(input logic [3:0] req, input int begin_delay, input int owned_len,
                           input bit end_with_error, input string tag);
        int  w;
        int  wait_cycles;
        grant_phase(req, tag, w);
        wait_cycles = (begin_delay < GRANT_TIMEOUT) ? begin_delay : GRANT_TIMEOUT;
        for (int k = 1; k <= wait_cycles; k++) begin
            tick();
            n_cmp++;
            if (status() !== {4'b0000, (k < GRANT_TIMEOUT), 2'b00}) begin
                n_err++;
                $display("FAIL %s wait[%0d]: got %b want %b", tag, k, status(),
                         {4'b0000, (k < GRANT_TIMEOUT), 2'b00});
            end
        end
        if (begin_delay >= GRANT_TIMEOUT) begin
            clear_inputs();
            return;
        end
        arb_bus.beginTransactionIn = 1'b1;
        arb_bus.endTransactionIn   = (owned_len == 0);
        tick();
        arb_bus.beginTransactionIn = 1'b0;
        arb_bus.endTransactionIn   = 1'b0;
        n_cmp++;
        if (status() !== {4'b0000, (owned_len != 0), 2'b00}) begin
            n_err++;
            $display("FAIL %s begin: got %b want %b", tag, status(), {4'b0000, (owned_len != 0), 2'b00});
        end
        if (owned_len == 0) begin
            clear_inputs();
            return;
        end
        for (int k = 1; k < owned_len; k++) begin
            arb_bus.dataValidIn = 1'($urandom);
            tick();
            n_cmp++;
            if (status() !== 7'b0000100) begin
                n_err++;
                $display("FAIL %s owned[%0d]: got %b want 0000100", tag, k, status());
            end
        end
        clear_inputs();
        if (end_with_error) arb_bus.errorIn = 1'b1;
        else                arb_bus.endTransactionIn = 1'b1;
        tick();
        clear_inputs();
        n_cmp++;
        if (status() !== 7'b0000000) begin
            n_err++;
            $display("FAIL %s release: got %b want 0000000", tag, status());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        last_grant = 3;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({status(), arb_bus.activeMaster} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_hold: got %b want 0", {status(), arb_bus.activeMaster});
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        n_cmp++;
        if (status() !== 7'b0) begin
            n_err++;
            $display("FAIL reset_idle: got %b want 0", status());
        end
    endtask

    task automatic test_single();
        run_txn(4'b0001, 0, 3, 1'b0, "single");
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 0, 1'b0, "rr");
    endtask

    task automatic test_grant_timeout();
        run_txn(4'b0100, GRANT_TIMEOUT, 0, 1'b0, "gtimeout");
        run_txn(4'b0101, 1, 2, 1'b0, "after_gtimeout");
    endtask

    task automatic test_bus_abort();
        int w;
        grant_phase(4'b0010, "abort", w);
        arb_bus.request = '0;
        arb_bus.beginTransactionIn = 1'b1;
        tick();
        arb_bus.beginTransactionIn = 1'b0;
        for (int k = 1; k < BUS_TIMEOUT; k++) begin
            tick();
            n_cmp++;
            if (status() !== 7'b0000100) begin
                n_err++;
                $display("FAIL abort_idle[%0d]: got %b want 0000100", k, status());
            end
        end
        tick();
        n_cmp++;
        if (status() !== 7'b0000111) begin
            n_err++;
            $display("FAIL abort_pulse: got %b want 0000111", status());
        end
        arb_bus.endTransactionIn = 1'b1;
        tick();
        arb_bus.endTransactionIn = 1'b0;
        n_cmp++;
        if (status() !== 7'b0000000) begin
            n_err++;
            $display("FAIL abort_release: got %b want 0000000", status());
        end
    endtask

    task automatic test_watchdog_refresh();
        int w;
        grant_phase(4'b1000, "refresh", w);
        arb_bus.request = '0;
        arb_bus.beginTransactionIn = 1'b1;
        tick();
        arb_bus.beginTransactionIn = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            arb_bus.dataValidIn = (k % 200 == 0);
            tick();
            n_cmp++;
            if (status() !== 7'b0000100) begin
                n_err++;
                $display("FAIL refresh[%0d]: got %b want 0000100", k, status());
            end
        end
        clear_inputs();
        arb_bus.endTransactionIn = 1'b1;
        tick();
        clear_inputs();
        n_cmp++;
        if (status() !== 7'b0000000) begin
            n_err++;
            $display("FAIL refresh_release: got %b want 0000000", status());
        end
    endtask

    task automatic test_reset_mid_transaction();
        int w;
        grant_phase(4'b0110, "midreset", w);
        arb_bus.request = '0;
        arb_bus.beginTransactionIn = 1'b1;
        tick();
        arb_bus.beginTransactionIn = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({status(), arb_bus.activeMaster} !== 9'b0) begin
            n_err++;
            $display("FAIL midreset_async: got %b want 0", {status(), arb_bus.activeMaster});
        end
        last_grant = 3;
        @(negedge clock);
        reset = 1'b1;
        tick();
        run_txn(4'b1000, 0, 2, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, GRANT_TIMEOUT + 1)),
                    int'($urandom_range(0, 20)), 1'($urandom), "random");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_grant_timeout();
        test_bus_abort();
        test_watchdog_refresh();
        test_reset_mid_transaction();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got running want finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
